// File: rtl/ps2_key_arbiter.sv
// ps2_key_arbiter: maps PS/2 scan codes to two players' controls, tracks held
// keys, queues press/release events per player and round-robins them onto a
// single registered event port.

// Per-player event queue. Wrap-bit pointers distinguish full from empty.
module ps2_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [3:0] din_i,
    input  logic       pop_i,
    output logic [3:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    logic [3:0]     mem_q [DEPTH];
    logic [PTR_W:0] wr_q, wr_d, rd_q, rd_d;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]) && (wr_q[PTR_W] != rd_q[PTR_W]);
    assign head_o  = mem_q[rd_q[PTR_W-1:0]];

    // Pointer advance; a push into a full queue is dropped even when popped this cycle
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_i && !full_o) wr_d = wr_q + 1'b1;
        if (pop_i && !empty_o) rd_d = rd_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: entries are only read between the pointers
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q[PTR_W-1:0]] <= din_i;
    end
endmodule

module ps2_key_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] key_data_i,
    input  logic       key_ready_i,
    input  logic       evt_ready_i,
    output logic       evt_valid_o,
    output logic       evt_player_o,
    output logic [2:0] evt_key_o,
    output logic       evt_press_o,
    output logic [4:0] p1_held_o,
    output logic [4:0] p2_held_o,
    input  logic       ovf_clr_i,
    output logic       p1_ovf_o,
    output logic       p2_ovf_o
);
    typedef struct packed {
        logic       player;
        logic [2:0] key;
        logic       press;
    } evt_t;

    logic            hit, dec_pl, held_cur, is_press, ev_go;
    logic [2:0]      dec_key;
    logic [1:0][4:0] held_q, held_d;
    logic [1:0]      ovf_q, ovf_d;
    logic [1:0]      push, pop, empty, full;
    logic [1:0][3:0] head;
    logic            load, any, gnt, last_q, last_d, vld_q, vld_d;
    evt_t            evt_q, evt_d;

    // Scan-code map: expand bit plus scancode selects player and key
    always_comb begin
        hit     = 1'b1;
        dec_pl  = 1'b0;
        dec_key = 3'd0;
        case ({key_data_i[9], key_data_i[7:0]})
            9'h01D: dec_key = 3'd0;
            9'h01B: dec_key = 3'd1;
            9'h01C: dec_key = 3'd2;
            9'h023: dec_key = 3'd3;
            9'h029: dec_key = 3'd4;
            9'h175: begin dec_pl = 1'b1; dec_key = 3'd0; end
            9'h172: begin dec_pl = 1'b1; dec_key = 3'd1; end
            9'h16B: begin dec_pl = 1'b1; dec_key = 3'd2; end
            9'h174: begin dec_pl = 1'b1; dec_key = 3'd3; end
            9'h05A: begin dec_pl = 1'b1; dec_key = 3'd4; end
            default: hit = 1'b0;
        endcase
    end

    // Only state changes produce events, which filters typematic repeats
    always_comb begin
        held_cur = held_q[dec_pl][dec_key];
        is_press = ~key_data_i[8];
        ev_go    = key_ready_i && hit && (is_press != held_cur);
        push     = {ev_go & dec_pl, ev_go & ~dec_pl};
        held_d   = held_q;
        if (ev_go) held_d[dec_pl][dec_key] = is_press;
        ovf_d    = (ovf_q & {2{~ovf_clr_i}}) | (push & full);
    end

    for (genvar p = 0; p < 2; p++) begin : g_q
        ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[p]),
            .din_i   ({dec_key, is_press}),
            .pop_i   (pop[p]),
            .head_o  (head[p]),
            .empty_o (empty[p]),
            .full_o  (full[p])
        );
    end

    // Round-robin only matters on a tie; a lone non-empty queue always wins
    always_comb begin
        load   = ~vld_q | evt_ready_i;
        any    = ~(&empty);
        gnt    = (~empty[0] & ~empty[1]) ? ~last_q : empty[0];
        last_d = (load & ~empty[0] & ~empty[1]) ? gnt : last_q;
        pop    = {load & ~empty[1] & gnt, load & ~empty[0] & ~gnt};
        vld_d  = vld_q;
        evt_d  = evt_q;
        if (load) begin
            vld_d = any;
            if (any) evt_d = {gnt, head[gnt]};
        end
    end

    // State registers; last-grant resets to P2 so P1 wins the first tie
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            held_q <= '0;
            ovf_q  <= '0;
            vld_q  <= 1'b0;
            evt_q  <= '0;
            last_q <= 1'b1;
        end else begin
            held_q <= held_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            evt_q  <= evt_d;
            last_q <= last_d;
        end
    end

    assign evt_valid_o  = vld_q;
    assign evt_player_o = evt_q.player;
    assign evt_key_o    = evt_q.key;
    assign evt_press_o  = evt_q.press;
    assign p1_held_o    = held_q[0];
    assign p2_held_o    = held_q[1];
    assign p1_ovf_o     = ovf_q[0];
    assign p2_ovf_o     = ovf_q[1];
endmodule

// File: tb/tb_ps2_key_arbiter.sv
// Bench for ps2_key_arbiter: directed scenarios then random traffic, all
// checked every cycle against a queue-based behavioural model.
module tb_ps2_key_arbiter;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1, key_ready = 1'b0, evt_ready = 1'b0, ovf_clr = 1'b0;
    logic [9:0] key_data = '0;
    logic       evt_valid, evt_player, evt_press, p1_ovf, p2_ovf;
    logic [2:0] evt_key;
    logic [4:0] p1_held, p2_held;

    int checks = 0, errors = 0;

    // {expand, scancode} per entry; index / 5 = player, index % 5 = key
    localparam logic [8:0] CODES [10] = '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h029,
                                         9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A};

    // Reference model state
    logic [3:0] mq0[$], mq1[$];
    logic [4:0] m_held[2];
    logic       m_ovf[2];
    logic       m_v, m_pl, m_pr, m_last;
    logic [2:0] m_key;

    always #5 clk = ~clk;

    ps2_key_arbiter #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .key_data_i(key_data), .key_ready_i(key_ready),
        .evt_ready_i(evt_ready), .evt_valid_o(evt_valid), .evt_player_o(evt_player),
        .evt_key_o(evt_key), .evt_press_o(evt_press), .p1_held_o(p1_held),
        .p2_held_o(p2_held), .ovf_clr_i(ovf_clr), .p1_ovf_o(p1_ovf), .p2_ovf_o(p2_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [9:0] d, output logic hit, output logic pl, output logic [2:0] k);
        logic [8:0] c;
        hit = 1'b0; pl = 1'b0; k = 3'd0;
        c = {d[9], d[7:0]};
        for (int i = 0; i < 10; i++)
            if (CODES[i] == c) begin
                hit = 1'b1; pl = (i >= 5); k = 3'(i % 5);
            end
    endtask

    task automatic model_update(input logic [9:0] kd, input logic kr, input logic er,
                                input logic oc, input logic r);
        logic hit, pl, press, g;
        logic [2:0] k;
        int n0, n1;
        logic [3:0] e;
        if (r) begin
            mq0.delete(); mq1.delete();
            m_held[0] = '0; m_held[1] = '0; m_ovf[0] = 0; m_ovf[1] = 0;
            m_v = 0; m_pl = 0; m_key = 0; m_pr = 0; m_last = 1;
            return;
        end
        n0 = mq0.size(); n1 = mq1.size();
        if (oc) begin m_ovf[0] = 0; m_ovf[1] = 0; end
        lookup(kd, hit, pl, k);
        press = ~kd[8];
        if (kr && hit && (press != m_held[pl][k])) begin
            m_held[pl][k] = press;
            if ((pl ? n1 : n0) == DEPTH) m_ovf[pl] = 1;
            else if (pl) mq1.push_back({k, press});
            else mq0.push_back({k, press});
        end
        if (!m_v || er) begin
            if (n0 == 0 && n1 == 0) m_v = 0;
            else begin
                if (n0 > 0 && n1 > 0) begin g = ~m_last; m_last = g; end
                else g = (n0 == 0);
                e = g ? mq1.pop_front() : mq0.pop_front();
                m_v = 1; m_pl = g; m_key = e[3:1]; m_pr = e[0];
            end
        end
    endtask

    task automatic compare_all();
        chk("evt_valid", evt_valid, m_v);
        chk("evt_player", evt_player, m_pl);
        chk("evt_key", evt_key, m_key);
        chk("evt_press", evt_press, m_pr);
        chk("p1_held", p1_held, m_held[0]);
        chk("p2_held", p2_held, m_held[1]);
        chk("p1_ovf", p1_ovf, m_ovf[0]);
        chk("p2_ovf", p2_ovf, m_ovf[1]);
    endtask

    // One clock: drive inputs, clock, advance model, compare after the edge
    task automatic cyc(input logic [9:0] kd, input logic kr, input logic er,
                       input logic oc = 1'b0, input logic r = 1'b0);
        key_data = kd; key_ready = kr; evt_ready = er; ovf_clr = oc; rst = r;
        @(posedge clk);
        model_update(kd, kr, er, oc, r);
        #1;
        compare_all();
    endtask

    initial begin
        int thr, idx;
        logic [8:0] c;
        logic [9:0] kd;

        // Reset
        cyc(10'h0, 0, 1, 0, 1);
        cyc(10'h0, 0, 1, 0, 1);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_held", {p1_held, p2_held}, 10'h0);

        // 1: single press latency
        cyc(10'h01D, 1, 1);
        chk("t1_held", p1_held, 5'b00001);
        chk("t1_not_yet", evt_valid, 1'b0);
        cyc(10'h0, 0, 1);
        chk("t1_evt", {evt_valid, evt_player, evt_key, evt_press}, 6'b1_0_000_1);
        cyc(10'h0, 0, 1);
        chk("t1_drop", evt_valid, 1'b0);

        // 2: typematic repeats then release (held already set from test 1)
        cyc(10'h01D, 1, 1); cyc(10'h01D, 1, 1); cyc(10'h11D, 1, 1);
        cyc(10'h0, 0, 1);
        chk("t2_rel", {evt_valid, evt_key, evt_press}, 5'b1_000_0);
        cyc(10'h0, 0, 1);
        chk("t2_held", p1_held, 5'b0);

        // 3: P2 then P1 under backpressure, then alternating ties
        cyc(10'h275, 1, 0); cyc(10'h029, 1, 0);
        chk("t3_p2_first", {evt_valid, evt_player, evt_key}, 5'b1_1_000);
        cyc(10'h0, 0, 1);
        chk("t3_p1_next", {evt_valid, evt_player, evt_key}, 5'b1_0_100);
        cyc(10'h0, 0, 0);
        cyc(10'h01B, 1, 0); cyc(10'h172, 1, 0); cyc(10'h023, 1, 0); cyc(10'h174, 1, 0);
        for (int i = 0; i < 6; i++) cyc(10'h0, 0, 1);

        // 4: overflow of P1 queue
        cyc(10'h0, 0, 1, 0, 1);
        cyc(10'h01D, 1, 0); cyc(10'h01B, 1, 0); cyc(10'h01C, 1, 0);
        cyc(10'h023, 1, 0); cyc(10'h029, 1, 0); cyc(10'h11D, 1, 0);
        chk("t4_ovf", {p1_ovf, p2_ovf}, 2'b10);
        cyc(10'h0, 0, 0, 1);
        chk("t4_clr", p1_ovf, 1'b0);
        for (int i = 0; i < 6; i++) cyc(10'h0, 0, 1);

        // 5: unmapped codes
        cyc(10'h21C, 1, 1); cyc(10'h0F0, 1, 1); cyc(10'h0, 0, 1);
        chk("t5_none", evt_valid, 1'b0);

        // 6: reset mid-operation, then first tie goes to P1
        cyc(10'h01D, 1, 0); cyc(10'h175, 1, 0); cyc(10'h029, 1, 0);
        cyc(10'h0, 0, 0, 0, 1);
        chk("t6_zero", {evt_valid, evt_player, evt_key, evt_press, p1_held, p2_held, p1_ovf, p2_ovf}, 18'h0);
        cyc(10'h01B, 1, 0); cyc(10'h0, 0, 0);
        cyc(10'h172, 1, 0); cyc(10'h01C, 1, 0);
        cyc(10'h0, 0, 1);
        chk("t6_tie_p1", {evt_player, evt_key}, 4'b0_010);
        for (int i = 0; i < 4; i++) cyc(10'h0, 0, 1);

        // Random traffic with varying consumer throughput
        thr = 80;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) thr = $urandom_range(5, 100);
            if ($urandom_range(0, 3) != 0) begin
                idx = $urandom_range(0, 9);
                c = CODES[idx];
                kd = {c[8], 1'($urandom_range(0, 1)), c[7:0]};
            end else kd = 10'($urandom);
            cyc(kd, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < thr),
                ($urandom_range(0, 31) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_arbiter.md
Name: ps2_key_arbiter

Overview:
- Sits directly behind the PS/2 receiver. Consumes its 10-bit decoded word {expand, break, scancode[7:0]} and single-cycle ready strobe.
- Maps fixed scan codes to two players' controls: 4 directions plus action each.
- Tracks held-key state per player and suppresses typematic repeats.
- Queues press/release events per player and shares one event output port between both queues with round-robin arbitration.

Parameters:
- FIFO_DEPTH, 4: entries per player event queue; power of two, 2..16.
- PTR_W, 2: log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock, same domain as the PS/2 receiver.
- rst  in  1  synchronous, active-high reset.
- key_data  in  10  {expand, break, scancode[7:0]}; valid only when key_ready=1.
- key_ready  in  1  single-cycle strobe marking a new key_data word.
- evt_ready  in  1  consumer accepts the event presented this cycle.
- evt_valid  out  1  event output register holds an event.
- evt_player  out  1  0=P1, 1=P2.
- evt_key  out  3  0=up, 1=down, 2=left, 3=right, 4=action.
- evt_press  out  1  1=press, 0=release.
- p1_held  out  5  held bitmap for P1, bit index = key index.
- p2_held  out  5  held bitmap for P2, bit index = key index.
- ovf_clr  in  1  clears the sticky overflow flags.
- p1_ovf  out  1  sticky: a P1 event was dropped because its queue was full.
- p2_ovf  out  1  sticky: a P2 event was dropped because its queue was full.

Behaviour:
- Reset (sync, highest priority, also mid-operation):
  - Both queues are emptied.
  - evt_valid=0, evt_player=0, evt_key=0, evt_press=0.
  - p1_held=0, p2_held=0, p1_ovf=0, p2_ovf=0.
  - Round-robin last-grant is set to P2, so P1 wins the first tie.
- Key map. Match is on expand bit plus scancode; break bit selects release.
  - P1 (expand=0): 1D=up, 1B=down, 1C=left, 23=right, 29=action.
  - P2 (expand=1): 75=up, 72=down, 6B=left, 74=right. P2 action is 5A with expand=0.
  - Any other code is ignored: no state change, no event.
- Decode, on a key_ready=1 cycle with a mapped code, all updated at that clock edge:
  - Press (break=0) when the held bit is 0: set held bit, enqueue {key, press=1}.
  - Press when the held bit is already 1 (typematic repeat): no event, held state unchanged.
  - Release (break=1) when the held bit is 1: clear held bit, enqueue {key, press=0}.
  - Release when the held bit is 0: ignored.
  - Held bits update even if the queue is full.
- Queues:
  - One FIFO per player, FIFO_DEPTH entries of {key[2:0], press}.
  - Pointers are PTR_W bits wide plus one wrap bit. Full means the low bits are equal and the wrap bits differ.
  - Enqueue while full: the event is dropped, the queue is unchanged, and the player's ovf flag is set.
  - A push and a pop on the same queue in the same cycle are both performed. A push to a full queue is still dropped even if that queue is popped in the same cycle.
- Output register and arbitration:
  - The register loads when evt_valid=0, or when evt_valid=1 and evt_ready=1.
  - If only one queue is non-empty, its head is popped into the register.
  - If both are non-empty, grant the player that is not the last-grant, then set last-grant to the winner.
  - If both are empty on a load cycle, evt_valid drops to 0.
  - Consumption and refill happen in the same cycle, giving 1 event per cycle throughput.
  - While evt_valid=1 and evt_ready=0, all evt_* outputs hold stable.
- Latency: key_ready sampled at edge N enters the queue at edge N. evt_valid is first visible after edge N+1 if the register was free. p*_held is visible after edge N.
- Overflow flags: ovf_clr clears them. If a set and an ovf_clr happen in the same cycle, the set wins.
- Ordering: events from one player come out in arrival order. No ordering is guaranteed between the two players.

Test Plan:
1. Reset, then key_data=0x01D with key_ready pulse, evt_ready=1 -> p1_held=5'b00001 after 1 cycle; evt_valid=1 with player=0, key=0, press=1 two cycles after the strobe; evt_valid=0 the next cycle.
2. Send 0x01D three times, then 0x11D -> exactly two events (press, then release of P1 up); p1_held returns to 0.
3. evt_ready=0; send 0x275 (P2 up press) then 0x029 (P1 action press) in the same idle window; then raise evt_ready -> output sequence is P2 up press (already loaded), then P1 action press. Repeat with both queues non-empty at the arbitration point -> grants alternate P1, P2, P1.
4. evt_ready=0 with FIFO_DEPTH=4; 6 distinct P1 press/release events -> register holds 1, queue holds 4, the sixth is dropped, p1_ovf=1, p2_ovf=0; pulse ovf_clr -> p1_ovf=0; drain -> 5 events in order.
5. Unmapped 0x01C with expand=1 (0x21C), and 0x0F0 -> no event, held bitmaps unchanged.
6. Assert rst while both queues are non-empty and keys are held -> next cycle all outputs are 0; the first post-reset tie is granted to P1.
